// File: rtl/gpio_v2_pkg.sv
// gpio_v2_pkg: shared definitions for the second-generation GPIO controller.
//   - Register word offsets (decoded from addr[5:2]).
//   - INT_TYPE / INT_POL bit encodings.
package gpio_v2_pkg;

    localparam int OFF_W = 4;

    localparam logic [OFF_W-1:0] REG_DATA_OUT  = 4'd0;
    localparam logic [OFF_W-1:0] REG_DATA_IN   = 4'd1;
    localparam logic [OFF_W-1:0] REG_DIR       = 4'd2;
    localparam logic [OFF_W-1:0] REG_INT_EN    = 4'd3;
    localparam logic [OFF_W-1:0] REG_INT_STAT  = 4'd4;
    localparam logic [OFF_W-1:0] REG_INT_TYPE  = 4'd5;
    localparam logic [OFF_W-1:0] REG_INT_POL   = 4'd6;
    localparam logic [OFF_W-1:0] REG_INT_BOTH  = 4'd7;
    localparam logic [OFF_W-1:0] REG_OUT_SET   = 4'd8;
    localparam logic [OFF_W-1:0] REG_OUT_CLR   = 4'd9;
    localparam logic [OFF_W-1:0] REG_OUT_TGL   = 4'd10;
    localparam logic [OFF_W-1:0] REG_DB_THRESH = 4'd11;
    localparam logic [OFF_W-1:0] REG_DB_EN     = 4'd12;

    // INT_TYPE bit encoding
    localparam logic INT_TYPE_EDGE  = 1'b0;
    localparam logic INT_TYPE_LEVEL = 1'b1;

    // INT_POL bit encoding (meaning depends on INT_TYPE)
    localparam logic INT_POL_RISE = 1'b0;  // edge
    localparam logic INT_POL_FALL = 1'b1;  // edge
    localparam logic INT_POL_LOW  = 1'b0;  // level
    localparam logic INT_POL_HIGH = 1'b1;  // level

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: single-pin debounce filter.
//   A change on sync_in must be held for thresh+1 consecutive cycles before
//   filt_out follows it. With en low the filter is transparent (one flop).
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   sync_in    : synchronised pad level
//   en         : debounce enable for this pin
//   thresh     : stability threshold (shared by all pins)
//   filt_out   : filtered pin level
module gpio_debounce #(
    parameter int DB_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sync_in,
    input  logic                en,
    input  logic [DB_WIDTH-1:0] thresh,
    output logic                filt_out
);

    logic [DB_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            filt_out <= 1'b0;
        end else if (!en) begin
            filt_out <= sync_in;
            cnt      <= '0;
        end else if (sync_in == filt_out) begin
            cnt <= '0;
        end else if (cnt >= thresh) begin
            // >= rather than == so that lowering thresh below an in-flight
            // count accepts the change instead of letting cnt wrap around.
            filt_out <= sync_in;
            cnt      <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_ctrl_v2.sv
// gpio_ctrl_v2: memory-mapped GPIO controller with input synchroniser,
// per-pin debounce, per-pin interrupt mode and atomic set/clr/toggle.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   addr, write_data      : bus address (addr[5:2] decoded) and write data
//   write_en, read_en     : single-cycle bus strobes
//   read_data, read_valid : registered read response, 1-cycle latency
//   gpio_in               : asynchronous pad inputs
//   gpio_out, gpio_oe     : pad output values (DATA_OUT) and enables (DIR)
//   gpio_irq              : registered interrupt request
module gpio_ctrl_v2
    import gpio_v2_pkg::*;
#(
    parameter int NUM_PINS    = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DB_WIDTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_en,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    input  logic [NUM_PINS-1:0]   gpio_in,
    output logic [NUM_PINS-1:0]   gpio_out,
    output logic [NUM_PINS-1:0]   gpio_oe,
    output logic                  gpio_irq
);

    logic [OFF_W-1:0]    offset;
    logic [NUM_PINS-1:0] wpins;

    logic [NUM_PINS-1:0] data_out, dir, int_en, int_stat;
    logic [NUM_PINS-1:0] int_type, int_pol, int_both, db_en;
    logic [DB_WIDTH-1:0] db_thresh;

    logic [SYNC_STAGES-1:0][NUM_PINS-1:0] sync_ff;
    logic [NUM_PINS-1:0] sync, filt, filt_prev;
    logic [NUM_PINS-1:0] rise, fall, hit, w1c;
    logic [DATA_WIDTH-1:0] rd_mux;

    // Only addr[5:2] and the low write_data bits carry meaning.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{addr, write_data};

    assign offset   = addr[5:2];
    assign wpins    = write_data[NUM_PINS-1:0];
    assign gpio_out = data_out;
    assign gpio_oe  = dir;

    // ---------------- input synchroniser ----------------
    always_ff @(posedge clk) begin
        if (rst) sync_ff <= '0;
        else     sync_ff <= {sync_ff[SYNC_STAGES-2:0], gpio_in};
    end
    assign sync = sync_ff[SYNC_STAGES-1];

    // ---------------- per-pin debounce + interrupt hit ----------------
    assign rise = filt & ~filt_prev;
    assign fall = ~filt & filt_prev;

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        gpio_debounce #(.DB_WIDTH(DB_WIDTH)) u_db (
            .clk      (clk),
            .rst      (rst),
            .sync_in  (sync[i]),
            .en       (db_en[i]),
            .thresh   (db_thresh),
            .filt_out (filt[i])
        );

        // INT_BOTH only matters for edge type, where it overrides POL.
        assign hit[i] = (int_type[i] == INT_TYPE_LEVEL)
                      ? ((int_pol[i] == INT_POL_HIGH) ? filt[i] : ~filt[i])
                      : (int_both[i] ? (rise[i] | fall[i])
                                     : ((int_pol[i] == INT_POL_FALL) ? fall[i] : rise[i]));
    end

    // ---------------- control registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            dir       <= '0;
            int_en    <= '0;
            int_type  <= '0;
            int_pol   <= '0;
            int_both  <= '0;
            db_en     <= '0;
            db_thresh <= '0;
        end else if (write_en) begin
            case (offset)
                REG_DATA_OUT:  data_out  <= wpins;
                REG_DIR:       dir       <= wpins;
                REG_INT_EN:    int_en    <= wpins;
                REG_INT_TYPE:  int_type  <= wpins;
                REG_INT_POL:   int_pol   <= wpins;
                REG_INT_BOTH:  int_both  <= wpins;
                REG_OUT_SET:   data_out  <= data_out | wpins;
                REG_OUT_CLR:   data_out  <= data_out & ~wpins;
                REG_OUT_TGL:   data_out  <= data_out ^ wpins;
                REG_DB_THRESH: db_thresh <= write_data[DB_WIDTH-1:0];
                REG_DB_EN:     db_en     <= wpins;
                default: ;
            endcase
        end
    end

    // ---------------- interrupt status / request ----------------
    assign w1c = (write_en && offset == REG_INT_STAT) ? wpins : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_prev <= '0;
            int_stat  <= '0;
            gpio_irq  <= 1'b0;
        end else begin
            filt_prev <= filt;
            // Set term is OR'd after the clear so a same-cycle hit survives.
            int_stat  <= (int_stat & ~w1c) | (hit & int_en);
            gpio_irq  <= |(int_stat & int_en);
        end
    end

    // ---------------- read path ----------------
    // Mux sees pre-edge register values, so a read coinciding with a write
    // to the same offset returns the old contents.
    always_comb begin
        rd_mux = '0;
        case (offset)
            REG_DATA_OUT:  rd_mux[NUM_PINS-1:0] = data_out;
            REG_DATA_IN:   rd_mux[NUM_PINS-1:0] = filt;
            REG_DIR:       rd_mux[NUM_PINS-1:0] = dir;
            REG_INT_EN:    rd_mux[NUM_PINS-1:0] = int_en;
            REG_INT_STAT:  rd_mux[NUM_PINS-1:0] = int_stat;
            REG_INT_TYPE:  rd_mux[NUM_PINS-1:0] = int_type;
            REG_INT_POL:   rd_mux[NUM_PINS-1:0] = int_pol;
            REG_INT_BOTH:  rd_mux[NUM_PINS-1:0] = int_both;
            REG_DB_THRESH: rd_mux[DB_WIDTH-1:0] = db_thresh;
            REG_DB_EN:     rd_mux[NUM_PINS-1:0] = db_en;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= read_en;
            if (read_en) read_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_gpio_ctrl_v2.sv
// tb_gpio_ctrl_v2: self-checking bench for gpio_ctrl_v2 (16 pins, 2 sync
// stages). Table of bus vectors, hand sequences for timing corners, then
// randomized register traffic and pad traffic against a reference model.
module tb_gpio_ctrl_v2;

    localparam int NP = 16;
    localparam logic [31:0] PMASK = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, write_data, read_data;
    logic        write_en, read_en, read_valid, gpio_irq;
    logic [NP-1:0] gpio_in, gpio_out, gpio_oe;

    int checks = 0;
    int errors = 0;

    gpio_ctrl_v2 #(.NUM_PINS(NP), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                   .SYNC_STAGES(2), .DB_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .addr(addr), .write_data(write_data),
        .write_en(write_en), .read_en(read_en), .read_data(read_data),
        .read_valid(read_valid), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_oe(gpio_oe), .gpio_irq(gpio_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        addr = 32'(off) << 2;
        write_data = d;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input int off, input logic [31:0] exp);
        addr = 32'(off) << 2;
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        chk({nm, "_vld"}, 32'(read_valid), 32'd1);
        chk(nm, read_data, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Hold a read of INT_STAT for 7 cycles after the caller changed a pad.
    // Status is expected from cycle 'first' on (3 sync/filter + 1 detect +
    // 1 read), and gpio_irq must appear on that same sample.
    task automatic watch_stat(input string nm, input logic [31:0] exp, input int first);
        for (int n = 1; n <= 7; n++) begin
            addr = 32'd4 << 2;
            read_en = 1'b1;
            tick();
            chk($sformatf("%s_stat_c%0d", nm, n), read_data, (n >= first) ? exp : 32'd0);
            chk($sformatf("%s_irq_c%0d", nm, n), 32'(gpio_irq),
                (n >= first && exp != 0) ? 32'd1 : 32'd0);
        end
        read_en = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [3:0]  off;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic [15:0] exp_out;
        logic [15:0] exp_oe;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    // reference register model: readback value per offset
    logic [31:0] m[16];

    task automatic model_write(input int off, input logic [31:0] d);
        case (off)
            0, 2, 5, 6, 7, 12: m[off] = d & PMASK;
            8:  m[0] = m[0] | (d & PMASK);
            9:  m[0] = m[0] & ~d;
            10: m[0] = m[0] ^ (d & PMASK);
            11: m[11] = d & 32'h0000_00FF;
            default: ;
        endcase
    endtask

    initial begin
        logic [15:0] hist[$];
        logic [15:0] g, expg;
        int off;
        logic w, r;
        logic [31:0] d;

        rst = 1'b1; addr = '0; write_data = '0; write_en = 1'b0;
        read_en = 1'b0; gpio_in = '0;
        tick(); tick();
        rst = 1'b0;

        // ---------- reset state ----------
        chk("rst_irq", 32'(gpio_irq), 32'd0);
        chk("rst_vld", 32'(read_valid), 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        chk("rst_out", 32'(gpio_out), 32'd0);
        chk("rst_oe", 32'(gpio_oe), 32'd0);
        for (int i = 0; i < 16; i++) rd_chk($sformatf("rst_reg%0d", i), i, 32'd0);

        // ---------- table-driven bus vectors ----------
        vecs[0]  = '{1'b1, 4'd2,  32'h0000_00FF, 32'h0,          16'h0000, 16'h00FF};
        vecs[1]  = '{1'b1, 4'd0,  32'h0000_00AA, 32'h0,          16'h00AA, 16'h00FF};
        vecs[2]  = '{1'b0, 4'd0,  32'h0,         32'h0000_00AA, 16'h0,    16'h0};
        vecs[3]  = '{1'b1, 4'd8,  32'h0000_0005, 32'h0,          16'h00AF, 16'h00FF};
        vecs[4]  = '{1'b0, 4'd0,  32'h0,         32'h0000_00AF, 16'h0,    16'h0};
        vecs[5]  = '{1'b1, 4'd10, 32'h0000_0081, 32'h0,          16'h002E, 16'h00FF};
        vecs[6]  = '{1'b0, 4'd0,  32'h0,         32'h0000_002E, 16'h0,    16'h0};
        vecs[7]  = '{1'b0, 4'd2,  32'h0,         32'h0000_00FF, 16'h0,    16'h0};
        vecs[8]  = '{1'b0, 4'd8,  32'h0,         32'h0,          16'h0,    16'h0};
        vecs[9]  = '{1'b1, 4'd13, 32'h0000_1234, 32'h0,          16'h002E, 16'h00FF};
        vecs[10] = '{1'b0, 4'd13, 32'h0,         32'h0,          16'h0,    16'h0};
        vecs[11] = '{1'b1, 4'd1,  32'h0000_FFFF, 32'h0,          16'h002E, 16'h00FF};
        vecs[12] = '{1'b0, 4'd1,  32'h0,         32'h0,          16'h0,    16'h0};
        vecs[13] = '{1'b1, 4'd11, 32'h0000_01FF, 32'h0,          16'h002E, 16'h00FF};
        vecs[14] = '{1'b0, 4'd11, 32'h0,         32'h0000_00FF, 16'h0,    16'h0};
        vecs[15] = '{1'b1, 4'd9,  32'h0000_0006, 32'h0,          16'h0028, 16'h00FF};
        vecs[16] = '{1'b0, 4'd0,  32'h0,         32'h0000_0028, 16'h0,    16'h0};
        vecs[17] = '{1'b1, 4'd5,  32'hFFFF_FFFF, 32'h0,          16'h0028, 16'h00FF};
        vecs[18] = '{1'b0, 4'd5,  32'h0,         32'h0000_FFFF, 16'h0,    16'h0};
        vecs[19] = '{1'b1, 4'd5,  32'h0,         32'h0,          16'h0028, 16'h00FF};

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                wr(int'(vecs[i].off), vecs[i].data);
                chk($sformatf("vec%0d_out", i), 32'(gpio_out), 32'(vecs[i].exp_out));
                chk($sformatf("vec%0d_oe", i), 32'(gpio_oe), 32'(vecs[i].exp_oe));
            end else begin
                rd_chk($sformatf("vec%0d_rd", i), int'(vecs[i].off), vecs[i].exp_rd);
            end
        end

        // ---------- same-cycle read+write returns old value ----------
        addr = 32'd2 << 2; write_data = 32'h0000_0F0F;
        write_en = 1'b1; read_en = 1'b1;
        tick();
        write_en = 1'b0; read_en = 1'b0;
        chk("rw_same_old", read_data, 32'h0000_00FF);
        chk("rw_same_vld", 32'(read_valid), 32'd1);
        rd_chk("rw_next_new", 2, 32'h0000_0F0F);
        tick();
        chk("rd_idle_vld", 32'(read_valid), 32'd0);
        chk("rd_idle_hold", read_data, 32'h0000_0F0F);
        chk("rw_oe", 32'(gpio_oe), 32'h0000_0F0F);

        // ---------- pad-to-DATA_IN latency, no debounce ----------
        do_reset();
        gpio_in[3] = 1'b1;
        tick(); tick();
        rd_chk("sync_lat_early", 1, 32'h0);
        rd_chk("sync_lat_exact", 1, 32'h8);

        // ---------- debounce: short pulse rejected, long level accepted ----------
        do_reset();
        gpio_in = '0;
        wr(12, 32'h1);
        wr(11, 32'd4);
        gpio_in[0] = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            addr = 32'd1 << 2; read_en = 1'b1;
            tick();
            if (n == 3) gpio_in[0] = 1'b0;
            chk($sformatf("db_pulse_c%0d", n), read_data, 32'h0);
        end
        gpio_in[0] = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            addr = 32'd1 << 2; read_en = 1'b1;
            tick();
            if (n == 10) gpio_in[0] = 1'b0;
            chk($sformatf("db_long_c%0d", n), read_data, (n >= 8) ? 32'h1 : 32'h0);
        end
        read_en = 1'b0;

        // ---------- edge interrupts: pin 2 falling, pin 5 both ----------
        do_reset();
        gpio_in = '0;
        wr(6, 32'h0004);
        wr(7, 32'h0020);
        wr(3, 32'h0024);
        tick(); tick();
        gpio_in[2] = 1'b1; watch_stat("p2_rise", 32'h0, 5);
        gpio_in[2] = 1'b0; watch_stat("p2_fall", 32'h4, 5);
        wr(4, 32'h0024);
        rd_chk("w1c_all", 4, 32'h0);
        chk("w1c_irq", 32'(gpio_irq), 32'd0);
        gpio_in[5] = 1'b1; watch_stat("p5_rise", 32'h20, 5);
        wr(4, 32'h0020);
        gpio_in[5] = 1'b0; watch_stat("p5_fall", 32'h20, 5);
        wr(3, 32'h0);
        tick();
        chk("mask_irq", 32'(gpio_irq), 32'd0);
        rd_chk("mask_keeps_stat", 4, 32'h20);
        wr(4, 32'h0024);

        // ---------- level re-assert and set-beats-clear ----------
        do_reset();
        gpio_in = '0;
        wr(5, 32'h0080);
        wr(6, 32'h0080);
        wr(3, 32'h0082);
        gpio_in[7] = 1'b1;
        repeat (6) tick();
        rd_chk("lvl_set", 4, 32'h80);
        wr(4, 32'h0080);
        rd_chk("lvl_reassert", 4, 32'h80);
        gpio_in[1] = 1'b1;
        repeat (6) tick();
        rd_chk("p1_rise", 4, 32'h82);
        wr(4, 32'h0002);
        rd_chk("p1_clear", 4, 32'h80);
        gpio_in[1] = 1'b0;
        repeat (6) tick();
        rd_chk("p1_fall_noset", 4, 32'h80);
        gpio_in[1] = 1'b1;
        repeat (3) tick();
        wr(4, 32'h0002);  // lands on the cycle the rise sets bit 1
        rd_chk("set_beats_clr", 4, 32'h82);

        // ---------- reset mid-debounce with everything pending ----------
        do_reset();
        gpio_in = '0;
        wr(5, 32'hFFFF);
        wr(3, 32'hFFFF);
        wr(12, 32'h1);
        wr(11, 32'd8);
        wr(2, 32'hFFFF);
        wr(0, 32'h1234);
        gpio_in[0] = 1'b1;
        repeat (4) tick();
        rd_chk("pre_rst_stat", 4, 32'hFFFF);
        chk("pre_rst_irq", 32'(gpio_irq), 32'd1);
        do_reset();
        chk("post_rst_irq", 32'(gpio_irq), 32'd0);
        chk("post_rst_vld", 32'(read_valid), 32'd0);
        chk("post_rst_rdata", read_data, 32'd0);
        chk("post_rst_out", 32'(gpio_out), 32'd0);
        chk("post_rst_oe", 32'(gpio_oe), 32'd0);
        for (int i = 2; i <= 12; i++)
            if (i < 8 || i > 10) rd_chk($sformatf("post_rst_reg%0d", i), i, 32'd0);
        repeat (8) tick();
        chk("post_rst_no_irq", 32'(gpio_irq), 32'd0);
        rd_chk("post_rst_no_stat", 4, 32'd0);
        rd_chk("post_rst_din", 1, 32'h1);

        // ---------- randomized register traffic vs register model ----------
        do_reset();
        gpio_in = '0;
        for (int i = 0; i < 16; i++) m[i] = '0;
        for (int it = 0; it < 200; it++) begin
            off = int'($urandom_range(0, 15));
            if (off == 3) off = 1;  // INT_EN left 0 so status stays quiet
            d = $urandom;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            addr = 32'(off) << 2; write_data = d;
            write_en = w; read_en = r;
            tick();
            write_en = 1'b0; read_en = 1'b0;
            if (r) chk($sformatf("rnd%0d_rd_off%0d", it, off), read_data, m[off]);
            chk($sformatf("rnd%0d_vld", it), 32'(read_valid), 32'(r));
            if (w) model_write(off, d);
            chk($sformatf("rnd%0d_out", it), 32'(gpio_out), m[0]);
            chk($sformatf("rnd%0d_oe", it), 32'(gpio_oe), m[2]);
        end

        // ---------- randomized pad traffic: DATA_IN = pad delayed 3+1 ----------
        do_reset();
        gpio_in = '0;
        repeat (4) tick();
        hist.delete();
        repeat (3) hist.push_back(16'h0);
        for (int it = 0; it < 60; it++) begin
            g = 16'($urandom);
            gpio_in = g;
            hist.push_back(g);
            addr = 32'd1 << 2; read_en = 1'b1;
            tick();
            expg = hist.pop_front();
            chk($sformatf("pad%0d", it), read_data, 32'(expg));
        end
        read_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
